// File: rtl/mult_booth_pkg.sv
// mult_booth_pkg: shared state encoding, widths and Booth pair codes (package mult_defs)
package mult_defs;
   localparam int MULT_WIDTH = 32;
   localparam int CNT_W = $clog2(MULT_WIDTH) + 1;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   typedef enum logic [1:0] {PAIR_NOP0 = 2'b00, PAIR_ADD = 2'b01, PAIR_SUB = 2'b10, PAIR_NOP1 = 2'b11} pair_t;
endpackage

// File: rtl/mult_booth_step.sv
// booth_step: one radix-2 Booth step (add/sub/none on the upper part, then arithmetic shift)
module booth_step
   import mult_defs::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic [2*WIDTH+1:0] p,
   input  logic [WIDTH:0]     m,
   output logic [2*WIDTH+1:0] p_next
);
   logic [WIDTH:0] upper;
   logic [WIDTH:0] sum;
   // Recode the low pair, update the WIDTH+1-bit upper part and shift right by one
   always_comb begin
      upper  = p[2*WIDTH+1:WIDTH+1];
      sum    = (pair_t'(p[1:0]) == PAIR_ADD) ? upper + m :
               (pair_t'(p[1:0]) == PAIR_SUB) ? upper - m : upper;
      p_next = {sum[WIDTH], sum, p[WIDTH:1]};
   end
endmodule

// File: rtl/mult_booth.sv
// mult_booth: sequential signed Booth multiplier; MULT_ZERO_SHORTCUT_EN enables the zero-operand fast path
module mult_booth
   import mult_defs::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             mult_control,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             mult_end,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t              state;
   logic [CW-1:0]       cnt;
   logic [2*WIDTH+1:0]  p;
   logic [2*WIDTH+1:0]  p_next;
   logic [WIDTH:0]      m;
   logic                zero_start;
   booth_step #(.WIDTH(WIDTH)) u_step (.p(p), .m(m), .p_next(p_next));
`ifdef MULT_ZERO_SHORTCUT_EN
   assign zero_start = (a_in == '0) || (b_in == '0);
`else
   assign zero_start = 1'b0;
`endif
   // Control FSM, step counter, accumulator and registered outputs; a zero start
   // runs a single all-zero step so DONE follows one edge later with product 0
   always_ff @(posedge clk) begin
      if (reset_in) begin
         state    <= IDLE;
         cnt      <= '0;
         p        <= '0;
         m        <= '0;
         hi_out   <= '0;
         lo_out   <= '0;
         mult_end <= 1'b0;
         busy     <= 1'b0;
      end else begin
         mult_end <= 1'b0;
         case (state)
            IDLE: if (mult_control) begin
               m     <= zero_start ? '0 : {a_in[WIDTH-1], a_in};
               p     <= zero_start ? '0 : {{(WIDTH+1){1'b0}}, b_in, 1'b0};
               cnt   <= zero_start ? LAST : '0;
               state <= RUN;
               busy  <= 1'b1;
            end
            RUN: begin
               p   <= p_next;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state            <= DONE;
                  {hi_out, lo_out} <= p_next[2*WIDTH:1];
                  mult_end         <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth: directed and random checks of mult_booth against a signed-product model
module tb_mult_booth;
   logic        clk = 1'b0;
   logic        reset_in = 1'b1;
   logic        mult_control = 1'b0;
   logic [31:0] a_in = '0;
   logic [31:0] b_in = '0;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        mult_end;
   logic        busy;
   int          total = 0;
   int          bad = 0;
`ifdef MULT_ZERO_SHORTCUT_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 32;
`endif

   mult_booth dut (
      .clk(clk), .reset_in(reset_in), .mult_control(mult_control),
      .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
      .mult_end(mult_end), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                         input int lat, input string tag);
      int k;
      a_in = a;
      b_in = b;
      mult_control = 1'b1;
      tick();
      mult_control = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'(1));
      k = 0;
      while (!mult_end && k < 60) begin
         tick();
         k++;
      end
      chk({tag, "_lat"}, 64'(k), 64'(lat));
      chk({tag, "_prod"}, {hi_out, lo_out}, exp);
      a_in = $urandom;
      b_in = $urandom;
      tick();
      chk({tag, "_after"}, 64'({mult_end, busy}), 64'(0));
      chk({tag, "_hold"}, {hi_out, lo_out}, exp);
   endtask

   initial begin
      int k;
      int pulses;
      logic [31:0] ra;
      logic [31:0] rb;
      repeat (2) tick();
      chk("reset_outs", {hi_out, lo_out}, 64'h0);
      chk("reset_flags", 64'({mult_end, busy}), 64'(0));
      reset_in = 1'b0;
      tick();

      run_op(32'd7, 32'd6, 64'h00000000_0000002A, 32, "pos");
      run_op(-32'sd3, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 32, "neg_a");
      run_op(32'd5, -32'sd3, 64'hFFFFFFFF_FFFFFFF1, 32, "neg_b");
      run_op(32'h80000000, 32'h80000000, 64'h40000000_00000000, 32, "min_min");
      run_op(32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 32, "max_min");

      a_in = 32'd7;
      b_in = 32'd6;
      mult_control = 1'b1;
      tick();
      mult_control = 1'b0;
      repeat (10) tick();
      a_in = 32'd2;
      b_in = 32'd2;
      mult_control = 1'b1;
      k = 10;
      while (!mult_end && k < 60) begin
         tick();
         k++;
      end
      chk("held_lat", 64'(k), 64'(32));
      chk("held_prod", {hi_out, lo_out}, 64'd42);
      mult_control = 1'b0;
      tick();
      chk("held_single", 64'({mult_end, busy}), 64'(0));
      run_op(32'd2, 32'd2, 64'd4, 32, "b2b");

      a_in = 32'd7;
      b_in = 32'd6;
      mult_control = 1'b1;
      tick();
      mult_control = 1'b0;
      repeat (10) tick();
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_prod", {hi_out, lo_out}, 64'h0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         if (mult_end) pulses++;
         tick();
      end
      chk("rst_no_end", 64'(pulses), 64'(0));
      run_op(32'd9, 32'd9, 64'h51, 32, "post_rst");

      run_op(32'd0, 32'h12345678, 64'h0, ZLAT, "zero_a");
      run_op(32'h12345678, 32'd0, 64'h0, ZLAT, "zero_b");

      for (int i = 0; i < 10; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i == 3) ra[31] = 1'b1;
         if (i == 4) rb[31] = 1'b1;
         run_op(ra, rb, model(ra, rb), 32, $sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
